// File: rtl/uart_echo_responder.sv
// UART echo responder: captures received bytes into a small FIFO and offers them to the transmitter.
// Define UART_ECHO_ERR_FILTER_EN to drop (but still count) bytes received with a framing error.
module uart_echo_responder #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_ready,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_error,
  input  logic                          tx_ready,
  output logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    err_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_IDLE} state_t;

  state_t                 state, state_nxt;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          head, tail;
  logic                   rx_prev, rx_edge, wr_ok, full, push, pop, load;

  assign rx_edge = rx_ready & ~rx_prev;
  assign full    = (fifo_count == DEPTH_C);
`ifdef UART_ECHO_ERR_FILTER_EN
  assign wr_ok   = ~rx_error;
`else
  assign wr_ok   = 1'b1;
`endif
  // A pop in the same cycle frees the head slot, so a full buffer can still accept.
  assign push    = rx_edge & wr_ok & (~full | pop);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: if (fifo_count != '0 && tx_ready) begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (!tx_ready) begin
        pop       = 1'b1;
        state_nxt = WAIT_IDLE;
      end
      WAIT_IDLE: if (tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_prev    <= 1'b0;
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      overflow   <= 1'b0;
      err_count  <= '0;
    end else begin
      state   <= state_nxt;
      rx_prev <= rx_ready;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (load) begin
        tx_data  <= mem[head];
        tx_valid <= 1'b1;
      end else if (pop) begin
        tx_valid <= 1'b0;
      end
      if (rx_edge && wr_ok && full && !pop) overflow <= 1'b1;
      if (rx_edge && rx_error && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[tail] <= rx_data;
  end
endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed self-checking bench for uart_echo_responder (default DATA_BITS=8, FIFO_DEPTH=4).
module tb_uart_echo_responder;
  logic       clk = 1'b0;
  logic       rst, rx_ready, rx_error, tx_ready;
  logic [7:0] rx_data, tx_data, err_count;
  logic       tx_valid, overflow;
  logic [2:0] fifo_count;
  int checks = 0;
  int errors = 0;

  uart_echo_responder #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data), .rx_error(rx_error),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .fifo_count(fifo_count),
    .overflow(overflow), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_error = e;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_error = 1'b0;
    tick();
  endtask

  // Release tx_ready until a byte is offered (bounded), check it, then accept it.
  task automatic expect_byte(input string tag, input logic [7:0] b);
    int n = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < 6) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(tx_valid), 1);
    chk({tag, "_data"}, 32'(tx_data), 32'(b));
    tx_ready = 1'b0;
    tick();
    chk({tag, "_drop"}, 32'(tx_valid), 0);
  endtask

  initial begin
    rst = 1'b1; rx_ready = 1'b0; rx_data = '0; rx_error = 1'b0; tx_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_err", 32'(err_count), 0);

    // Single byte and N+2 latency
    rx_data = 8'hAA; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("lat_count", 32'(fifo_count), 1);
    chk("lat_n1_valid", 32'(tx_valid), 0);
    tick();
    chk("lat_n2_valid", 32'(tx_valid), 1);
    chk("lat_data", 32'(tx_data), 32'h0AA);
    tx_ready = 1'b0;
    tick();
    chk("single_drop", 32'(tx_valid), 0);
    chk("single_count", 32'(fifo_count), 0);

    // Ordering with tx held off
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hB4, 1'b0);
    chk("ord_count", 32'(fifo_count), 3);
    chk("ord_hold_valid", 32'(tx_valid), 0);
    expect_byte("ord0", 8'h12);
    expect_byte("ord1", 8'h34);
    expect_byte("ord2", 8'hB4);
    chk("ord_empty", 32'(fifo_count), 0);

    // Overflow at depth 4
    do_reset();
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 1; i <= 4; i++) expect_byte("ovf_drain", 8'(i));
    tx_ready = 1'b1;
    tick(); tick(); tick();
    chk("ovf_no5th", 32'(tx_valid), 0);
    chk("ovf_drained", 32'(fifo_count), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    do_reset();
    chk("ovf_cleared", 32'(overflow), 0);

    // Held rx_ready captures once
    tx_ready = 1'b0;
    rx_data = 8'h5A; rx_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rx_ready = 1'b0;
    tick();
    chk("held_count", 32'(fifo_count), 1);

    // rx_ready high on the first cycle after reset is an edge
    rx_data = 8'h3C; rx_ready = 1'b1;
    do_reset();
    tick();
    rx_ready = 1'b0;
    chk("post_rst_edge", 32'(fifo_count), 1);
    do_reset();

    // Error path
    tx_ready = 1'b1;
    send_byte(8'h55, 1'b1);
    chk("err_one", 32'(err_count), 1);
`ifdef UART_ECHO_ERR_FILTER_EN
    chk("err_filt_valid", 32'(tx_valid), 0);
    chk("err_filt_count", 32'(fifo_count), 0);
`else
    chk("err_echo_valid", 32'(tx_valid), 1);
    chk("err_echo_data", 32'(tx_data), 32'h055);
`endif
    tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) send_byte(8'(i), 1'b1);
    chk("err_sat", 32'(err_count), 255);

    // Reset mid-SEND
    do_reset();
    tx_ready = 1'b1;
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    chk("ms_valid", 32'(tx_valid), 1);
    chk("ms_count", 32'(fifo_count), 2);
    do_reset();
    chk("ms_rst_valid", 32'(tx_valid), 0);
    chk("ms_rst_count", 32'(fifo_count), 0);
    tick(); tick(); tick();
    chk("ms_no_stale", 32'(tx_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_echo_responder.md
UART_ECHO_RESPONDER -- requirements
Module: uart_echo_responder

Interface
REQ-001 Parameter: DATA_BITS, default 8, byte width on RX and TX sides.
REQ-002 Parameter: FIFO_DEPTH, default 4, echo buffer entries; power of two, >= 2.
REQ-003 Port: clk  input  1  system clock; all logic is on its rising edge.
REQ-004 Port: rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 Port: rx_ready  input  1  byte-available indication from uart_receiver.
REQ-006 Port: rx_data  input  DATA_BITS  received byte; valid while rx_ready is high.
REQ-007 Port: rx_error  input  1  framing error flag for the current rx_data.
REQ-008 Port: tx_ready  input  1  uart_transmitter idle; goes low when it accepts a byte.
REQ-009 Port: tx_data  output  DATA_BITS  byte offered to uart_transmitter.
REQ-010 Port: tx_valid  output  1  tx_data offered.
REQ-011 Port: fifo_count  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-012 Port: overflow  output  1  sticky flag: a byte was dropped because the buffer was full.
REQ-013 Port: err_count  output  8  count of rx_error captures; saturates at 255.

Function
REQ-014 Capture SHALL occur only on an rx_ready rising edge (high now, low in the previous cycle); a held-high rx_ready captures exactly once.
REQ-015 Captured byte SHALL be written to the FIFO tail one cycle after the edge; fifo_count SHALL update in the same cycle.
REQ-016 Capture while fifo_count == FIFO_DEPTH with no pop in that cycle: byte dropped, overflow set to 1.
REQ-017 Capture and pop in the same cycle with a full buffer: push accepted, fifo_count unchanged, overflow not set.
REQ-018 Pointers SHALL wrap modulo FIFO_DEPTH; bytes SHALL leave in arrival order.
REQ-019 Capture with rx_error high SHALL increment err_count, holding at 255.
REQ-020 TX FSM states: IDLE, SEND, WAIT_IDLE.
REQ-021 IDLE: if fifo_count > 0 and tx_ready == 1, register the head byte into tx_data, set tx_valid = 1, go to SEND.
REQ-022 SEND: hold tx_valid and tx_data stable until tx_ready is sampled 0; in that cycle pop the head, clear tx_valid on the next edge, go to WAIT_IDLE.
REQ-023 WAIT_IDLE: stay until tx_ready is sampled 1, then go to IDLE; no new byte is offered in this state.
REQ-024 Latency: with an empty buffer, tx_ready high and FSM in IDLE, an rx_ready rising edge in cycle N SHALL give tx_valid = 1 in cycle N+2.
REQ-025 tx_data SHALL change only on the IDLE-to-SEND transition.

Reset
REQ-026 With rst high at a clock edge: FSM to IDLE, pointers and fifo_count 0, tx_valid 0, tx_data 0, overflow 0, err_count 0, and the rx_ready edge history cleared to 0.
REQ-027 Reset mid-transfer (SEND or WAIT_IDLE) SHALL discard the buffer and the in-flight byte; no byte is re-offered after reset.
REQ-028 An rx_ready that is high in the first cycle after reset SHALL count as a rising edge.

Configuration
REQ-029 Macro UART_ECHO_ERR_FILTER_EN defined: bytes captured with rx_error high are counted but not written to the FIFO.
REQ-030 Macro undefined: erroneous bytes are counted and echoed like any other byte; all other behaviour is identical.

Verification
REQ-031 Single byte: rx_ready edge with rx_data 0xAA, tx_ready 1 -> tx_valid high 2 cycles later with tx_data 0xAA; drop tx_ready to 0 -> tx_valid 0 next cycle, fifo_count 0.
REQ-032 Ordering: rx bytes 0x12, 0x34, 0xB4 while tx_ready is held 0 -> fifo_count 3; then release the TX handshake three times -> tx_data sequence 0x12, 0x34, 0xB4.
REQ-033 Overflow (depth 4): 5 captures with tx_ready held 0 -> fifo_count 4, overflow 1; the fifth byte is never offered; overflow stays 1 until rst.
REQ-034 Error path: capture 0x55 with rx_error 1 -> err_count 1; 0x55 echoed with the macro undefined, not echoed and fifo_count 0 with it defined; 300 error captures -> err_count 255.
REQ-035 Reset mid-SEND: rst pulse while tx_valid is 1 -> next cycle tx_valid 0, fifo_count 0, FSM IDLE; no stale byte offered afterwards.
REQ-036 Held rx_ready: rx_ready high for 10 cycles -> exactly one capture, fifo_count increases by 1.
